// File: rtl/intersection_phase_arbiter_if.sv
// Purpose: bundles the sensor/timing inputs and the lamp/grant outputs of the
//          intersection phase arbiter so the controller and its environment
//          connect through one port.
// Signals:
//   tick        1-cycle timing enable (one timing unit per pulse)
//   req         per-approach vehicle sensor, bit i = vehicle waiting at i
//   preempt     emergency request, level
//   preempt_id  approach to serve on preempt (must be < N_APP)
//   lights      lamps of approach i at [3i+2:3i]: 100 red, 010 yellow, 001 green
//   grant_id    approach holding right-of-way (valid when grant_vld)
//   grant_vld   high in GREEN and YELLOW
//   phase       00 IDLE, 01 GREEN, 10 YELLOW, 11 ALLRED
// Modports: master drives the inputs (environment), slave is the arbiter.
interface intersection_phase_arbiter_if #(
  parameter int N_APP = 4
);
  logic                 tick;
  logic [N_APP-1:0]     req;
  logic                 preempt;
  logic [2:0]           preempt_id;
  logic [3*N_APP-1:0]   lights;
  logic [2:0]           grant_id;
  logic                 grant_vld;
  logic [1:0]           phase;

  modport master (
    output tick, req, preempt, preempt_id,
    input  lights, grant_id, grant_vld, phase
  );

  modport slave (
    input  tick, req, preempt, preempt_id,
    output lights, grant_id, grant_vld, phase
  );
endinterface

// File: rtl/intersection_phase_arbiter.sv
// Purpose: shares the single right-of-way of an N-approach intersection.
//          Round-robin green among waiting approaches with min/max green,
//          yellow and all-red clearance timed in ticks, plus one emergency
//          preempt. Drives the 3-bit lamps of every approach.
// Ports:
//   clk     system clock
//   rst_n   asynchronous, active-low reset
//   io_arb  slave side of intersection_phase_arbiter_if
//           (tick, req, preempt, preempt_id in; lights, grant_id,
//            grant_vld, phase out)
module intersection_phase_arbiter #(
  parameter int N_APP     = 4,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YEL_T     = 3,
  parameter int ALLRED_T  = 1,
  parameter int TMR_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  intersection_phase_arbiter_if.slave io_arb
);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_ALLRED = 2'b11
  } phase_t;

  // Timer comparisons are done one bit wider so timer+1 can never wrap.
  localparam logic [TMR_W:0] LP_MIN  = (TMR_W+1)'(MIN_GREEN);
  localparam logic [TMR_W:0] LP_MAX  = (TMR_W+1)'(MAX_GREEN);
  localparam logic [TMR_W:0] LP_YEL  = (TMR_W+1)'(YEL_T);
  localparam logic [TMR_W:0] LP_AR   = (TMR_W+1)'(ALLRED_T);
  localparam logic [2:0]     LP_LAST = 3'(N_APP-1);

  phase_t           r_state;
  phase_t           w_stateNext;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timerNext;
  logic [2:0]       r_grant;
  logic [2:0]       w_grantNext;
  logic [2:0]       r_rrPtr;
  logic [2:0]       w_rrPtrNext;

  logic [N_APP-1:0] w_grantOh;
  logic             w_reqG;
  logic             w_others;
  logic [TMR_W:0]   w_tPlus;
  logic [N_APP-1:0] w_reqRot;
  logic [3:0]       w_sum;
  logic [2:0]       w_winner;
  logic             w_found;
  logic [2:0]       w_rrAfter;

  // One-hot of the current grant, used to split req into "mine" and "others".
  always_comb begin
    w_grantOh = '0;
    for (int i = 0; i < N_APP; i++) begin
      w_grantOh[i] = (r_grant == 3'(i));
    end
  end

  assign w_reqG   = |(io_arb.req & w_grantOh);
  assign w_others = |(io_arb.req & ~w_grantOh);
  assign w_tPlus  = {1'b0, r_timer} + (TMR_W+1)'(1);

  // Requests rotated so bit 0 is the approach at rr_ptr; the first set bit k
  // of the rotated vector is approach (rr_ptr + k) mod N_APP.
  assign w_reqRot = N_APP'({io_arb.req, io_arb.req} >> r_rrPtr);

  // Arbitration: preempt wins outright, otherwise round-robin from rr_ptr.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    if (io_arb.preempt) begin
      w_winner = io_arb.preempt_id;
      w_found  = 1'b1;
    end else begin
      for (int k = 0; k < N_APP; k++) begin
        if (!w_found && w_reqRot[k]) begin
          w_sum = 4'(r_rrPtr) + 4'(k);
          if (w_sum >= 4'(N_APP)) begin
            w_sum = w_sum - 4'(N_APP);
          end
          w_winner = w_sum[2:0];
          w_found  = 1'b1;
        end
      end
    end
  end

  assign w_rrAfter = (w_winner == LP_LAST) ? 3'd0 : w_winner + 3'd1;

  // Next-state logic. Every state change clears the timer, so a tick that
  // coincides with entering a state never counts toward that state.
  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer;
    w_grantNext = r_grant;
    w_rrPtrNext = r_rrPtr;
    unique case (r_state)
      PH_IDLE: begin
        if (w_found) begin
          w_stateNext = PH_GREEN;
          w_grantNext = w_winner;
          w_rrPtrNext = w_rrAfter;
          w_timerNext = '0;
        end
      end
      PH_GREEN: begin
        if (io_arb.preempt && (io_arb.preempt_id != r_grant)) begin
          w_stateNext = PH_YELLOW;
          w_timerNext = '0;
        end else if (io_arb.tick) begin
          // A preempt for the approach already green freezes timed exits.
          if (!io_arb.preempt && w_others &&
              (((w_tPlus >= LP_MIN) && !w_reqG) || (w_tPlus >= LP_MAX))) begin
            w_stateNext = PH_YELLOW;
            w_timerNext = '0;
          end else if (w_tPlus >= LP_MAX) begin
            w_timerNext = LP_MAX[TMR_W-1:0];
          end else begin
            w_timerNext = w_tPlus[TMR_W-1:0];
          end
        end
      end
      PH_YELLOW: begin
        if (io_arb.tick) begin
          if (w_tPlus >= LP_YEL) begin
            w_stateNext = PH_ALLRED;
            w_timerNext = '0;
          end else begin
            w_timerNext = w_tPlus[TMR_W-1:0];
          end
        end
      end
      PH_ALLRED: begin
        if (io_arb.tick) begin
          if (w_tPlus >= LP_AR) begin
            w_timerNext = '0;
            if (w_found) begin
              w_stateNext = PH_GREEN;
              w_grantNext = w_winner;
              w_rrPtrNext = w_rrAfter;
            end else begin
              w_stateNext = PH_IDLE;
            end
          end else begin
            w_timerNext = w_tPlus[TMR_W-1:0];
          end
        end
      end
      default: begin
        w_stateNext = PH_IDLE;
        w_timerNext = '0;
      end
    endcase
  end

  // State, timer, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PH_IDLE;
      r_timer <= '0;
      r_grant <= '0;
      r_rrPtr <= '0;
    end else begin
      r_state <= w_stateNext;
      r_timer <= w_timerNext;
      r_grant <= w_grantNext;
      r_rrPtr <= w_rrPtrNext;
    end
  end

  // Moore lamp decode: only the granted approach can be non-red, and only
  // in GREEN or YELLOW.
  always_comb begin
    io_arb.lights = '0;
    for (int i = 0; i < N_APP; i++) begin
      io_arb.lights[3*i +: 3] = 3'b100;
      if (r_grant == 3'(i)) begin
        if (r_state == PH_GREEN) begin
          io_arb.lights[3*i +: 3] = 3'b001;
        end else if (r_state == PH_YELLOW) begin
          io_arb.lights[3*i +: 3] = 3'b010;
        end
      end
    end
  end

  assign io_arb.grant_vld = (r_state == PH_GREEN) || (r_state == PH_YELLOW);
  assign io_arb.grant_id  = r_grant;
  assign io_arb.phase     = r_state;

endmodule
